// File: rtl/pipe_pkg.sv
// Shared types and defaults for the inter-stage pipeline buffer.
package pipe_pkg;

  // Occupancy of a pipeline stage: nothing held, one beat, or one beat plus a skid beat.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  // Default stage bundle width and the payload shown while the stage is empty.
  localparam int unsigned PIPE_W_DEF = 98;
  localparam logic [PIPE_W_DEF-1:0] PIPE_BUBBLE_DEF = {PIPE_W_DEF{1'b0}};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, cleared only by rst.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: step by one unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake, optional skid entry,
// synchronous flush (bubble insertion) and a saturating stall counter.
// The main entry register drives out_data directly, so there is no
// combinational path from the input side to the output payload.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned   W      = 98,
  parameter int unsigned   SKID   = 1,
  parameter logic [W-1:0]  BUBBLE = W'(PIPE_BUBBLE_DEF),
  parameter int unsigned   CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  state_e       state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         out_valid_q, out_valid_d;
  logic         in_ready_q, in_ready_d;
  logic         accept;
  logic         emit;
  logic         stall;

  // In skid mode in_ready comes from a flop; otherwise it looks through to out_ready.
  assign in_ready = (SKID != 0) ? in_ready_q : (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign emit     = out_valid_q & out_ready;
  assign stall    = out_valid_q & ~out_ready;

  // Next-state and entry updates; flush wins over any accept, a concurrent emit still completes downstream.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_MAIN;
            main_d  = in_data;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_MAIN: begin
          if (accept && emit) begin
            state_d = ST_MAIN;
            main_d  = in_data;
          end else if (accept) begin
            // Only reachable with a skid entry; single-entry mode blocks this via in_ready.
            if (SKID != 0) begin
              state_d = ST_SKID;
              skid_d  = in_data;
            end else begin
              state_d = ST_MAIN;
            end
          end else if (emit) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE;
          end else begin
            state_d = ST_MAIN;
          end
        end
        ST_SKID: begin
          // in_ready is low here, so the only event is the main beat leaving.
          if (emit) begin
            state_d = ST_MAIN;
            main_d  = skid_q;
            skid_d  = BUBBLE;
          end else begin
            state_d = ST_SKID;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_SKID);
  end

  // Stage state, both entries and the registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= BUBBLE;
      skid_q      <= BUBBLE;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = main_q;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: skid mode, single-entry mode and a narrow counter.
module tb_pipe_stage_buf;

  localparam logic [15:0] BUB = 16'hBEEF;

  logic clk = 1'b0;
  logic rst;

  // Skid-mode instance
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [15:0] a_in_data, a_out_data, a_stall;
  // Single-entry instance
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [15:0] b_in_data, b_out_data, b_stall;
  // Skid-mode instance with a 4-bit stall counter
  logic        c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [15:0] c_in_data, c_out_data;
  logic [3:0]  c_stall;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.W(16), .SKID(1), .BUBBLE(BUB), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .stall_cnt(a_stall));

  pipe_stage_buf #(.W(16), .SKID(0), .BUBBLE(BUB), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .stall_cnt(b_stall));

  pipe_stage_buf #(.W(16), .SKID(1), .BUBBLE(BUB), .CNT_W(4)) u_c (
    .clk(clk), .rst(rst), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .stall_cnt(c_stall));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = 16'h0000; a_out_ready = 1'b0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = 16'h0000; b_out_ready = 1'b0;
    c_flush = 1'b0; c_in_valid = 1'b0; c_in_data = 16'h0000; c_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(a_out_valid), 32'd0);
    check("rst_data",  32'(a_out_data),  32'(BUB));
    check("rst_stall", 32'(a_stall),     32'd0);
    check("rst_ready", 32'(a_in_ready),  32'd1);
    check("rst_ready_noskid", 32'(b_in_ready), 32'd1);
    rst = 1'b0;
    tick();

    // Streaming 0x0001..0x0010, one beat per cycle, 1-cycle latency
    a_out_ready = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      a_in_valid = (i < 16);
      a_in_data  = 16'(i + 1);
      #1;
      check("stream_ready", 32'(a_in_ready), 32'd1);
      if (i >= 1) begin
        check("stream_valid", 32'(a_out_valid), 32'd1);
        check("stream_data",  32'(a_out_data),  32'(i));
      end
      tick();
    end
    a_in_valid = 1'b0;
    #1;
    check("stream_drain_valid", 32'(a_out_valid), 32'd0);
    check("stream_drain_data",  32'(a_out_data),  32'(BUB));
    check("stream_stall", 32'(a_stall), 32'd0);

    // Backpressure: 0xA, 0xB with out_ready low
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 16'h000A;
    #1;
    check("bp_ready_1st", 32'(a_in_ready), 32'd1);
    tick();
    a_in_data = 16'h000B;
    #1;
    check("bp_ready_2nd", 32'(a_in_ready), 32'd1);
    check("bp_data_a0", 32'(a_out_data), 32'h000A);
    tick();
    a_in_valid = 1'b0;
    #1;
    check("bp_ready_low", 32'(a_in_ready), 32'd0);
    check("bp_data_a1", 32'(a_out_data), 32'h000A);
    check("bp_stall1", 32'(a_stall), 32'd1);
    tick();
    repeat (3) tick();
    check("bp_valid_hold", 32'(a_out_valid), 32'd1);
    check("bp_data_hold", 32'(a_out_data), 32'h000A);
    check("bp_stall5", 32'(a_stall), 32'd5);
    a_out_ready = 1'b1;
    #1;
    check("bp_rel_a", 32'(a_out_data), 32'h000A);
    tick();
    check("bp_rel_b", 32'(a_out_data), 32'h000B);
    check("bp_rel_valid", 32'(a_out_valid), 32'd1);
    check("bp_rel_ready", 32'(a_in_ready), 32'd1);
    check("bp_rel_stall", 32'(a_stall), 32'd5);
    tick();
    check("bp_empty", 32'(a_out_valid), 32'd0);

    // Flush race in SKID state with a beat offered
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 16'h0001;
    tick();
    a_in_data = 16'h0002;
    tick();
    a_in_data = 16'h000C; a_flush = 1'b1;
    #1;
    check("fr_skid_ready", 32'(a_in_ready), 32'd0);
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    #1;
    check("fr_valid", 32'(a_out_valid), 32'd0);
    check("fr_data", 32'(a_out_data), 32'(BUB));
    check("fr_ready", 32'(a_in_ready), 32'd1);
    check("fr_stall_kept", 32'(a_stall), 32'd7);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("fr_no_emit", 32'(a_out_valid), 32'd0);
    end

    // Flush in MAIN while a beat is emitted and another offered
    a_in_valid = 1'b1; a_in_data = 16'h0007;
    tick();
    a_in_data = 16'h000C; a_flush = 1'b1;
    #1;
    check("fm_data", 32'(a_out_data), 32'h0007);
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    #1;
    check("fm_valid", 32'(a_out_valid), 32'd0);
    check("fm_data_bub", 32'(a_out_data), 32'(BUB));
    tick();
    check("fm_no_c", 32'(a_out_valid), 32'd0);

    // Reset with two beats held
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 16'h0011;
    tick();
    a_in_data = 16'h0022;
    tick();
    a_in_valid = 1'b0;
    #1;
    check("mr_pre_stall", 32'(a_stall), 32'd8);
    check("mr_pre_ready", 32'(a_in_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("mr_valid", 32'(a_out_valid), 32'd0);
    check("mr_data",  32'(a_out_data),  32'(BUB));
    check("mr_stall", 32'(a_stall),     32'd0);
    check("mr_ready", 32'(a_in_ready),  32'd1);
    tick();
    rst = 1'b0;
    a_out_ready = 1'b1;
    tick();
    check("mr_nothing_left", 32'(a_out_valid), 32'd0);

    // Single-entry mode: combinational in_ready and same-cycle replace
    b_in_valid = 1'b1; b_in_data = 16'h0005; b_out_ready = 1'b0;
    #1;
    check("ns_ready_empty", 32'(b_in_ready), 32'd1);
    tick();
    b_in_data = 16'h0006;
    #1;
    check("ns_ready_stall", 32'(b_in_ready), 32'd0);
    check("ns_data5", 32'(b_out_data), 32'h0005);
    b_out_ready = 1'b1;
    #1;
    check("ns_ready_comb", 32'(b_in_ready), 32'd1);
    tick();
    b_in_valid = 1'b0;
    #1;
    check("ns_valid6", 32'(b_out_valid), 32'd1);
    check("ns_data6", 32'(b_out_data), 32'h0006);
    tick();
    check("ns_empty", 32'(b_out_valid), 32'd0);
    check("ns_bub", 32'(b_out_data), 32'(BUB));

    // Saturation with a 4-bit counter
    c_in_valid = 1'b1; c_in_data = 16'h0003; c_out_ready = 1'b0;
    tick();
    c_in_valid = 1'b0;
    repeat (14) tick();
    check("sat_14", 32'(c_stall), 32'd14);
    repeat (6) tick();
    check("sat_15", 32'(c_stall), 32'd15);
    check("sat_data", 32'(c_out_data), 32'h0003);
    c_flush = 1'b1;
    tick();
    c_flush = 1'b0;
    #1;
    check("sat_flush_keep", 32'(c_stall), 32'd15);
    check("sat_flush_valid", 32'(c_out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
